// File: rtl/mvb_pkg.sv
// Shared MVB definitions: frame-buffer state encoding and word/frame constants.
package mvb_pkg;

  localparam int MVB_WORD_W      = 16;
  localparam int MVB_MAX_WORDS   = 16;
  localparam int MVB_WORD_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_READOUT = 2'd3
  } mvb_state_t;

endpackage

// File: rtl/mvb_word_ram.sv
// Frame word store: one synchronous write port, one registered read port.
// Contents are not reset; only the read register is cleared by reset.
module mvb_word_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_3M,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Store an incoming word at the write address.
  always_ff @(posedge clk_3M) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read: data appears the cycle after re, and holds otherwise.
  always_ff @(posedge clk_3M) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mvb_frame_buffer.sv
// Groups deserialized MVB words into a frame (closed by an inter-word idle
// timeout), holds one frame, and serves it one word per rd_en request.
//
// Read port handshake: rd_en is a request with no back-pressure. Each rd_en
// sampled while a frame is held and unread words remain returns exactly one
// word on the next cycle with rd_valid=1; rd_last accompanies the final word.
// rd_en=0 stalls the readout. Requests at any other time are ignored.
module mvb_frame_buffer
  import mvb_pkg::*;
#(
  parameter int MAX_WORDS    = MVB_MAX_WORDS,
  parameter int IDLE_TIMEOUT = 48,
  parameter int LEN_W        = 5
) (
  input  logic                  clk_3M,
  input  logic                  rst,
  input  logic [MVB_WORD_W-1:0] word_in,
  input  logic                  word_valid,
  output logic                  frame_ready,
  output logic [LEN_W-1:0]      frame_len,
  output logic                  frame_ovf,
  input  logic                  rd_en,
  output logic [MVB_WORD_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  frame_drop,
  output mvb_state_t            dbg_state
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_WORDS);
  localparam logic [TW-1:0]    TMO_LAST = TW'(IDLE_TIMEOUT - 1);

  mvb_state_t       state_q;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic [TW-1:0]    tmo;
  logic             ovf_flag;

  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic                  ram_re;
  logic [AW-1:0]         ram_raddr;
  logic                  rd_is_last;

  assign dbg_state  = state_q;
  assign rd_is_last = (rd_ptr == frame_len - 1'b1);

  // RAM port requests derived from the current state and inputs.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr[AW-1:0];
    ram_re    = 1'b0;
    ram_raddr = rd_ptr[AW-1:0];
    case (state_q)
      ST_IDLE: begin
        if (word_valid) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
        end
      end
      ST_COLLECT: begin
        if (word_valid && (wr_ptr < MAX_L)) ram_we = 1'b1;
      end
      ST_HOLD, ST_READOUT: begin
        if (rd_en && (rd_ptr < frame_len)) ram_re = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame FSM with pointers, idle timer, flags and registered outputs.
  always_ff @(posedge clk_3M) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tmo         <= '0;
      ovf_flag    <= 1'b0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      frame_ovf   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      frame_drop <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (word_valid) begin
            wr_ptr   <= LEN_W'(1);
            tmo      <= '0;
            ovf_flag <= 1'b0;
            state_q  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // A word arriving on the expiry cycle keeps the frame open.
          if (word_valid) begin
            if (wr_ptr < MAX_L) wr_ptr <= wr_ptr + 1'b1;
            else                ovf_flag <= 1'b1;
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            state_q     <= ST_HOLD;
            frame_ready <= 1'b1;
            frame_len   <= wr_ptr;
            frame_ovf   <= ovf_flag;
            rd_ptr      <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_HOLD, ST_READOUT: begin
          // Only one frame fits; anything arriving now is discarded.
          if (word_valid) frame_drop <= 1'b1;
          if (ram_re) begin
            rd_valid <= 1'b1;
            rd_last  <= rd_is_last;
            rd_ptr   <= rd_ptr + 1'b1;
            if (rd_is_last) begin
              state_q     <= ST_IDLE;
              frame_ready <= 1'b0;
              frame_len   <= '0;
              frame_ovf   <= 1'b0;
            end else begin
              state_q <= ST_READOUT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mvb_word_ram #(
    .DEPTH (MAX_WORDS),
    .W     (MVB_WORD_W),
    .AW    (AW)
  ) u_ram (
    .clk_3M (clk_3M),
    .rst    (rst),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (word_in),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_mvb_frame_buffer.sv
// Bench for mvb_frame_buffer: table of frame cases plus directed sequences
// for timing, overflow, busy-drop, timeout-edge and reset corner cases.
module tb_mvb_frame_buffer;
  import mvb_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk_3M = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic        frame_ready;
  logic [4:0]  frame_len;
  logic        frame_ovf;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        frame_drop;
  mvb_state_t  dbg_state;

  always #5 clk_3M = ~clk_3M;

  mvb_frame_buffer #(
    .MAX_WORDS    (16),
    .IDLE_TIMEOUT (48),
    .LEN_W        (5)
  ) dut (
    .clk_3M      (clk_3M),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .frame_ovf   (frame_ovf),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .frame_drop  (frame_drop),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          n_words;
    int          gap;
    logic [15:0] base;
    int          exp_len;
    logic        exp_ovf;
  } frame_vec_t;

  frame_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 after the edge.
  task automatic cycle();
    @(posedge clk_3M);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    word_in    = w;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
  endtask

  // Cycles from the call until frame_ready rises (bounded).
  task automatic wait_ready(output int k);
    k = 0;
    while (!frame_ready && k < 200) begin
      cycle();
      k++;
    end
    check("frame_ready_rise", 32'(frame_ready), 32'd1);
  endtask

  // Hold rd_en until rd_last; compare each word against the expected queue.
  task automatic drain(input string name, input int exp_n);
    int got;
    got   = 0;
    rd_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (rd_valid) begin
        if (exp_q.size() > 0) check({name, "_word"}, 32'(rd_data), 32'(exp_q.pop_front()));
        else                  check({name, "_extra_word"}, 32'(rd_data), 32'hFFFF_FFFF);
        got++;
        if (rd_last) break;
      end
    end
    rd_en = 1'b0;
    check({name, "_count"}, 32'(got), 32'(exp_n));
    check({name, "_ready_clr"}, 32'(frame_ready), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    int k;
    logic [15:0] w;

    vecs[0] = '{n_words: 1,  gap: 5,  base: 16'hA5A5, exp_len: 1,  exp_ovf: 1'b0};
    vecs[1] = '{n_words: 4,  gap: 16, base: 16'h0100, exp_len: 4,  exp_ovf: 1'b0};
    vecs[2] = '{n_words: 16, gap: 16, base: 16'h8000, exp_len: 16, exp_ovf: 1'b0};
    vecs[3] = '{n_words: 18, gap: 16, base: 16'h1357, exp_len: 16, exp_ovf: 1'b1};
    vecs[4] = '{n_words: 17, gap: 3,  base: 16'hFFFF, exp_len: 16, exp_ovf: 1'b1};

    // Reset with word_valid toggling.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word_valid = i[0];
      word_in    = 16'h5555;
      rd_en      = 1'b1;
      cycle();
    end
    word_valid = 1'b0;
    rd_en      = 1'b0;
    check("rst_ready", 32'(frame_ready), 32'd0);
    check("rst_len",   32'(frame_len),   32'd0);
    check("rst_ovf",   32'(frame_ovf),   32'd0);
    check("rst_data",  32'(rd_data),     32'd0);
    check("rst_valid", 32'(rd_valid),    32'd0);
    check("rst_last",  32'(rd_last),     32'd0);
    check("rst_drop",  32'(frame_drop),  32'd0);
    check("rst_state", 32'(dbg_state),   32'(ST_IDLE));
    rst = 1'b1;
    cycle();

    // Basic frame: ready exactly 48 cycles after last strobe, then readout.
    send_word(16'h1234);
    repeat (15) cycle();
    send_word(16'hABCD);
    repeat (15) cycle();
    send_word(16'h0F0F);
    wait_ready(k);
    check("basic_ready_latency", 32'(k), 32'd48);
    check("basic_len",   32'(frame_len), 32'd3);
    check("basic_ovf",   32'(frame_ovf), 32'd0);
    check("basic_state", 32'(dbg_state), 32'(ST_HOLD));
    rd_en = 1'b1;
    cycle();
    check("basic_d0", 32'(rd_data),  32'h1234);
    check("basic_v0", 32'(rd_valid), 32'd1);
    check("basic_l0", 32'(rd_last),  32'd0);
    cycle();
    check("basic_d1", 32'(rd_data),  32'hABCD);
    check("basic_l1", 32'(rd_last),  32'd0);
    cycle();
    check("basic_d2", 32'(rd_data),  32'h0F0F);
    check("basic_l2", 32'(rd_last),  32'd1);
    check("basic_ready_clr", 32'(frame_ready), 32'd0);
    check("basic_len_clr",   32'(frame_len),   32'd0);
    // rd_en after rd_last / in IDLE is ignored.
    cycle();
    check("basic_post_valid", 32'(rd_valid), 32'd0);
    check("basic_post_state", 32'(dbg_state), 32'(ST_IDLE));
    rd_en = 1'b0;
    cycle();

    // Table-driven frames, including overflow cases.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n_words; i++) begin
        w = vecs[v].base + 16'(i) * 16'h0111;
        if (i < 16) exp_q.push_back(w);
        send_word(w);
        if (i < vecs[v].n_words - 1) repeat (vecs[v].gap - 1) cycle();
      end
      wait_ready(k);
      check($sformatf("vec%0d_len", v), 32'(frame_len), 32'(vecs[v].exp_len));
      check($sformatf("vec%0d_ovf", v), 32'(frame_ovf), 32'(vecs[v].exp_ovf));
      drain($sformatf("vec%0d", v), vecs[v].exp_len);
      cycle();
    end

    // Busy drop in HOLD, then a drop plus stall in READOUT.
    send_word(16'h0A0A);
    repeat (4) cycle();
    send_word(16'h0B0B);
    repeat (4) cycle();
    send_word(16'h0C0C);
    wait_ready(k);
    send_word(16'hDEAD);
    check("hold_drop_pulse", 32'(frame_drop), 32'd1);
    cycle();
    check("hold_drop_clear", 32'(frame_drop), 32'd0);
    check("hold_len_kept",   32'(frame_len),  32'd3);
    rd_en = 1'b1;
    cycle();
    check("ro_d0", 32'(rd_data), 32'h0A0A);
    rd_en = 1'b0;
    send_word(16'hBEEF);
    check("ro_drop_pulse", 32'(frame_drop), 32'd1);
    check("ro_stall_valid", 32'(rd_valid), 32'd0);
    check("ro_stall_state", 32'(dbg_state), 32'(ST_READOUT));
    exp_q.push_back(16'h0B0B);
    exp_q.push_back(16'h0C0C);
    drain("ro_rest", 2);
    cycle();

    // Timeout edge: a word on the tmo==47 cycle joins the frame.
    send_word(16'h1111);
    repeat (47) cycle();
    check("edge_still_open", 32'(frame_ready), 32'd0);
    send_word(16'h2222);
    check("edge_state", 32'(dbg_state), 32'(ST_COLLECT));
    wait_ready(k);
    check("edge_latency", 32'(k), 32'd48);
    check("edge_len", 32'(frame_len), 32'd2);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    drain("edge", 2);
    cycle();

    // Reset mid-readout, then a fresh one-word frame.
    for (int i = 0; i < 4; i++) send_word(16'h4000 + 16'(i));
    wait_ready(k);
    check("mid_len", 32'(frame_len), 32'd4);
    rd_en = 1'b1;
    cycle();
    check("mid_d0", 32'(rd_data), 32'h4000);
    cycle();
    check("mid_d1", 32'(rd_data), 32'h4001);
    rd_en = 1'b0;
    rst   = 1'b0;
    cycle();
    rst = 1'b1;
    check("mid_rst_valid", 32'(rd_valid),    32'd0);
    check("mid_rst_ready", 32'(frame_ready), 32'd0);
    check("mid_rst_state", 32'(dbg_state),   32'(ST_IDLE));
    cycle();
    send_word(16'h7777);
    wait_ready(k);
    check("fresh_len", 32'(frame_len), 32'd1);
    exp_q.push_back(16'h7777);
    drain("fresh", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mvb_frame_buffer.md
Name: mvb_frame_buffer

Overview:
- Sits directly downstream of the MVB receive deserializer.
- Consumes its 16-bit words and one-cycle word-valid strobes, and groups consecutive words into one frame using an inter-word idle timeout.
- Stores the frame in a single buffer and presents it to the frame-decoding logic through a registered, one-word-per-request read port.
- Reports overflow and frames dropped while busy.

Parameters:
- MAX_WORDS, 16, buffer depth in 16-bit words; 16 = longest MVB slave frame payload.
- IDLE_TIMEOUT, 48, clk_3M cycles with no word_valid after which an open frame is closed. Must be > 16, one word time.
- LEN_W, 5, width of frame_len; must hold the value MAX_WORDS.

Ports:
- clk_3M, in, 1, 3 MHz bit clock.
- rst, in, 1, synchronous, active-low reset.
- word_in, in, 16, received word from the deserializer. Sampled only when word_valid=1.
- word_valid, in, 1, one-cycle strobe marking a new word.
- frame_ready, out, 1, a closed frame is held and available for reading.
- frame_len, out, LEN_W, number of valid words in the held frame (1..MAX_WORDS).
- frame_ovf, out, 1, the held frame was truncated because it exceeded MAX_WORDS.
- rd_en, in, 1, request the next word of the held frame.
- rd_data, out, 16, word returned for a rd_en.
- rd_valid, out, 1, rd_data valid this cycle.
- rd_last, out, 1, qualifies rd_valid; marks the final word of the frame.
- frame_drop, out, 1, one-cycle pulse when a word arrives while a frame is held or being read, and is discarded.

Behaviour:
- Reset (rst=0 at posedge clk_3M):
  - State goes to IDLE; write pointer, read pointer and timeout counter go to 0.
  - All outputs go to 0: frame_ready, frame_len, frame_ovf, rd_data, rd_valid, rd_last, frame_drop.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-readout abandons the frame with no further pulses.
- States: IDLE, COLLECT, HOLD, READOUT.
- IDLE:
  - word_valid=1 writes word_in to buf[0] and sets wr_ptr=1, tmo=0.
  - Moves to COLLECT.
- COLLECT:
  - tmo increments each cycle without word_valid.
  - word_valid=1 with wr_ptr<MAX_WORDS: writes buf[wr_ptr], increments wr_ptr, clears tmo.
  - word_valid=1 with wr_ptr==MAX_WORDS: word discarded, ovf_flag set, tmo cleared (frame still open).
  - When tmo reaches IDLE_TIMEOUT-1 with no word_valid in that cycle, go to HOLD. Next cycle: frame_ready=1, frame_len=wr_ptr, frame_ovf=ovf_flag.
  - Timeout expiry and word_valid in the same cycle: the word wins, tmo clears, the frame stays open.
- HOLD:
  - frame_ready=1; frame_len and frame_ovf stay stable.
  - rd_en=1 moves to READOUT and issues read of buf[0].
- READOUT:
  - Each cycle with rd_en=1 and rd_ptr<frame_len: on the next clock rd_data=buf[rd_ptr] and rd_valid=1, then rd_ptr increments. Read latency is 1 cycle.
  - rd_last=1 together with the word at index frame_len-1.
  - On that cycle state returns to IDLE and frame_ready, frame_len and frame_ovf clear.
  - rd_en=0 stalls: no rd_valid, pointer holds.
  - rd_en after rd_last, or while in IDLE/COLLECT, is ignored.
- Busy rule: a word_valid in HOLD or READOUT produces a frame_drop pulse on the next cycle and is discarded. The held frame is unaffected.
- Word arriving in the same cycle as the READOUT→IDLE transition: dropped with frame_drop. The new frame begins only on the next word_valid.
- Words are stored unmodified. No CRC or parity check here; frame decoding handles that downstream.

Decomposition:
- Shared package mvb_pkg holds:
  - state encoding (IDLE/COLLECT/HOLD/READOUT);
  - constants MVB_WORD_W=16, MVB_MAX_WORDS=16, MVB_WORD_CYCLES=16.
- The buffer is one natural sub-module: mvb_word_ram, MAX_WORDS x 16, one synchronous write port and one registered read port.
- The FSM, counters and flags stay in the top module.

Test Plan:
- Reset: hold rst=0 for 4 cycles with word_valid toggling → all outputs 0, state IDLE.
- Basic frame: 3 words 0x1234, 0xABCD, 0x0F0F at 16-cycle spacing, then silence → frame_ready=1 exactly 48 cycles after the last strobe; frame_len=3, frame_ovf=0. With rd_en held high: rd_data gives 0x1234, 0xABCD, 0x0F0F on consecutive cycles, rd_last on the third, then frame_ready=0.
- Overflow: 18 words → frame_len=16, frame_ovf=1; words 17 and 18 absent from readout.
- Busy drop: frame held, a word strobe arrives → frame_drop pulses once. Readout is still identical to the held frame.
- Timeout edge: word_valid on exactly the cycle tmo=IDLE_TIMEOUT-1 → frame stays open, and that word becomes part of the frame.
- Reset mid-readout: after 2 of 4 words are read, rst=0 for 1 cycle → rd_valid=0, frame_ready=0. The next word starts a fresh frame with frame_len counting from 1.
